// File: rtl/hvsync_recovery.sv
`default_nettype none
// ============================================================================
// Module   : hvsync_recovery
// Brief    : Rebuilds beam position from raw hsync/vsync and tracks timing lock.
// Revision : 1.0 - initial release
// ============================================================================
module hvsync_recovery #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_BOTTOM    = 10,
    parameter int V_SYNC      = 2,
    parameter int V_TOP       = 33,
    parameter int SYNC_OFFSET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        display_on,
    output logic        locked,
    output logic        new_frame,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [7:0]  err_count
);

    localparam int c_h_total_i      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_h_sync_start_i = H_DISPLAY + H_FRONT;
    localparam int c_v_total_i      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int c_v_sync_start_i = V_DISPLAY + V_BOTTOM;

    localparam logic [9:0]  c_h_last       = 10'(c_h_total_i - 1);
    localparam logic [9:0]  c_v_last       = 10'(c_v_total_i - 1);
    // The source registers sync one tick after its position, so the rise
    // is seen one tick later still; reload with the position after that.
    localparam logic [9:0]  c_h_reload     = 10'((c_h_sync_start_i + SYNC_OFFSET + 1) % c_h_total_i);
    localparam logic [9:0]  c_v_reload     = 10'(c_v_sync_start_i);
    localparam logic [9:0]  c_h_disp       = 10'(H_DISPLAY);
    localparam logic [9:0]  c_v_disp       = 10'(V_DISPLAY);
    localparam logic [10:0] c_h_total      = 11'(c_h_total_i);
    localparam logic [10:0] c_h_timeout_m1 = 11'(2 * c_h_total_i - 1);
    localparam logic [9:0]  c_v_total      = 10'(c_v_total_i);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_err_inc;

    logic        r_hs_d;
    logic        r_vs_d;
    logic [9:0]  r_hpos;
    logic [9:0]  r_vpos;
    logic [10:0] r_h_meas;
    logic [9:0]  r_v_meas;
    logic        r_h_seen;
    logic [10:0] r_line_len;
    logic [9:0]  r_frame_lines;
    logic [7:0]  r_err_count;
    logic        r_locked;
    logic        r_new_frame;

    logic        w_hrise;
    logic        w_vrise;
    logic        w_hpos_last;
    logic        w_vpos_last;
    logic        w_hwrap;
    logic        w_line_bad;
    logic        w_frame_bad;
    logic        w_timeout;

    assign w_hrise     = en & hsync_in & ~r_hs_d;
    assign w_vrise     = en & vsync_in & ~r_vs_d;
    assign w_hpos_last = (r_hpos == c_h_last);
    assign w_vpos_last = (r_vpos == c_v_last);
    assign w_hwrap     = w_hpos_last & ~w_hrise;
    assign w_line_bad  = w_hrise & r_h_seen & (r_h_meas != c_h_total);
    assign w_frame_bad = w_vrise & (r_v_meas != c_v_total);
    assign w_timeout   = en & ~w_hrise & (r_h_meas == c_h_timeout_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_UNLOCKED;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_locked <= (w_state_next == ST_LOCKED);
        end
    end

    // Every fault term already carries en, so the state holds when en=0.
    always_comb begin
        w_state_next = r_state;
        w_err_inc    = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_vrise) w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_line_bad | w_timeout)      w_state_next = ST_UNLOCKED;
                else if (w_vrise & ~w_frame_bad) w_state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_line_bad | w_frame_bad | w_timeout) begin
                    w_state_next = ST_UNLOCKED;
                    w_err_inc    = 1'b1;
                end
            end
            default: w_state_next = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_hpos        <= 10'd0;
            r_vpos        <= 10'd0;
            r_h_meas      <= 11'd0;
            r_v_meas      <= 10'd0;
            r_h_seen      <= 1'b0;
            r_line_len    <= 11'd0;
            r_frame_lines <= 10'd0;
            r_err_count   <= 8'd0;
            r_new_frame   <= 1'b0;
        end else begin
            r_new_frame <= en & r_locked & w_hwrap & w_vpos_last & ~w_vrise;
            if (en) begin
                r_hs_d <= hsync_in;
                r_vs_d <= vsync_in;

                if (w_hrise)          r_hpos <= c_h_reload;
                else if (w_hpos_last) r_hpos <= 10'd0;
                else                  r_hpos <= r_hpos + 10'd1;

                if (w_vrise)          r_vpos <= c_v_reload;
                else if (w_hwrap)     r_vpos <= w_vpos_last ? 10'd0 : r_vpos + 10'd1;

                if (w_hrise)          r_h_meas <= 11'd1;
                else if (~&r_h_meas)  r_h_meas <= r_h_meas + 11'd1;

                if (w_hrise & r_h_seen) r_line_len <= r_h_meas;

                if (w_timeout)        r_h_seen <= 1'b0;
                else if (w_hrise)     r_h_seen <= 1'b1;

                // A coincident hrise belongs to the old frame, so it is dropped.
                if (w_vrise) begin
                    r_v_meas      <= 10'd0;
                    r_frame_lines <= r_v_meas;
                end else if (w_hrise & ~&r_v_meas) begin
                    r_v_meas <= r_v_meas + 10'd1;
                end

                if (w_err_inc & ~&r_err_count) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign hpos        = r_hpos;
    assign vpos        = r_vpos;
    assign locked      = r_locked;
    assign new_frame   = r_new_frame;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign err_count   = r_err_count;
    assign display_on  = r_locked & (r_hpos < c_h_disp) & (r_vpos < c_v_disp);

endmodule
`default_nettype wire

// File: doc/hvsync_recovery.md
Name: hvsync_recovery

Overview:
- Receiver side of the VGA sync interface. Consumes registered hsync/vsync from an `hvsync_generator_enabled`-style source, or from an external pin after synchronization.
- Rebuilds the beam position (hpos/vpos) and display_on, checks line and frame timing, and reports lock.
- Used by overlay/capture logic that has raw sync but no position counters.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, back porch
- V_DISPLAY, 480, active lines
- V_BOTTOM, 10, vertical front porch
- V_SYNC, 2, vsync lines
- V_TOP, 33, vertical back porch
- SYNC_OFFSET, 1, source pipeline delay in pixel ticks between position and sync edge
- Derived: H_TOTAL=800, H_SYNC_START=656, V_TOTAL=525, V_SYNC_START=490

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  pixel-tick enable; all state advances only when en=1
- hsync_in  in  1  horizontal sync, active-high
- vsync_in  in  1  vertical sync, active-high
- hpos  out  10  recovered horizontal position
- vpos  out  10  recovered vertical position
- display_on  out  1  locked && hpos<H_DISPLAY && vpos<V_DISPLAY (combinational)
- locked  out  1  timing verified
- new_frame  out  1  one-clk pulse at recovered (0,0)
- line_len  out  11  last measured hsync rise-to-rise period, in ticks
- frame_lines  out  10  last measured lines between vsync rises
- err_count  out  8  saturating count of timing faults while locked

Behaviour:
- Reset (async): all outputs 0; internal hs_d, vs_d, h_meas, v_meas = 0; h_seen=0; state=UNLOCKED.
- Nothing changes when en=0.
- Edge detection:
  - hs_d<=hsync_in and vs_d<=vsync_in each en tick.
  - hrise = en & hsync_in & ~hs_d; vrise likewise.
- hpos:
  - On hrise: hpos <= (H_SYNC_START+SYNC_OFFSET+1) mod H_TOTAL.
  - Else: hpos increments, wrapping H_TOTAL-1 -> 0.
  - With generator-fed stimulus, hpos equals generator hpos on every clock after the first hrise.
- vpos:
  - Increments when hpos wraps to 0, wrapping V_TOTAL-1 -> 0.
  - On vrise: vpos <= V_SYNC_START; this takes priority over the increment in the same tick; hpos is unaffected.
- h_meas (11-bit, saturates at 2047):
  - Counts en ticks; reset to 1 on hrise.
  - On hrise with h_seen=1: line_len <= h_meas. h_seen is then set.
- v_meas:
  - Counts hrise events; reset to 0 on vrise.
  - On vrise: frame_lines <= v_meas.
- Faults:
  - line_bad: hrise with h_seen && h_meas != H_TOTAL.
  - frame_bad: vrise && v_meas != V_TOTAL.
  - timeout: h_meas reaches 2*H_TOTAL. On timeout, h_seen <= 0.
- State machine:
  - UNLOCKED: on vrise -> CHECK.
  - CHECK:
    - line_bad or timeout -> UNLOCKED.
    - vrise with !frame_bad and no line_bad in the frame -> LOCKED.
    - vrise with frame_bad -> stay in CHECK (the new frame measurement starts).
  - LOCKED:
    - Any line_bad, frame_bad or timeout -> UNLOCKED, and err_count += 1 (saturates at 255, never clears except on reset).
- locked = (state==LOCKED), registered. It deasserts on the clock after the fault tick.
- new_frame: registered pulse, 1 clk wide. Asserted after an en tick in which locked=1 and hpos wraps 799->0 while vpos wraps 524->0.
- Simultaneous hrise+vrise: both handled in the same tick. v_meas resets to 0; the hrise is not counted into the new frame.
- Reset mid-lock: immediate return to the reset values above; relock needs a fresh vrise plus one full good frame.

Test Plan:
- Generator-fed, en every 4th clk, both blocks released from reset together -> locked=1 within 2 frames of the first vrise; line_len=800, frame_lines=525; hpos/vpos equal generator hpos/vpos every clk thereafter.
- Locked stream -> new_frame pulses exactly once per 800*525 en ticks, one clk wide, coincident with recovered (0,0); display_on matches generator display_on.
- One line shortened to 799 ticks while locked -> locked falls the clock after that hrise; err_count=1; relock after the next vsync plus one clean frame.
- hsync held low for 1600 en ticks -> timeout; locked=0; err_count increments; hpos keeps free-running.
- Frame of 524 lines -> frame_lines=524; in CHECK, stays CHECK (locked=0); next 525-line frame -> locked=1.
- Async reset asserted mid-line while locked -> all outputs 0 immediately, without waiting for a clk edge; en held 0 for 100 clks -> hpos/vpos/line_len unchanged.
